// File: rtl/vote_tally_arbiter_if.sv
// vote_tally_arbiter_if: booth request/grant and election status bundle
//   master : drives start, finish, req, vote; receives ack, phase, tallies, result display
//   slave  : the tally arbiter side of the same signals
interface vote_tally_arbiter_if #(
   parameter int NUM_BOOTHS = 2,
   parameter int CNT_W      = 8
);
   logic                    start;
   logic                    finish;
   logic [NUM_BOOTHS-1:0]   req;
   logic [2*NUM_BOOTHS-1:0] vote;
   logic [NUM_BOOTHS-1:0]   ack;
   logic [1:0]              phase;
   logic [CNT_W-1:0]        count_c1;
   logic [CNT_W-1:0]        count_c2;
   logic [CNT_W-1:0]        count_nulo;
   logic [1:0]              result_sel;
   logic [CNT_W-1:0]        result_value;
   logic                    result_valid;
   modport master (
      output start, finish, req, vote,
      input  ack, phase, count_c1, count_c2, count_nulo, result_sel, result_value, result_valid
   );
   modport slave (
      input  start, finish, req, vote,
      output ack, phase, count_c1, count_c2, count_nulo, result_sel, result_value, result_valid
   );
endinterface

// File: rtl/vote_tally_arbiter.sv
// vote_tally_arbiter: round-robin shared vote tally for NUM_BOOTHS booths with election phase control
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/finish strobes and per-booth req/vote in; ack, phase, C1/C2/Nulo tallies,
//                  result selector/value/valid out
module vote_tally_arbiter #(
   parameter int NUM_BOOTHS = 2,
   parameter int CNT_W      = 8
) (
   input logic                 clock,
   input logic                 reset,
   vote_tally_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
   typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, CLOSED = 2'd2} phase_t;
   phase_t                phase_q;
   logic                  start_q, finish_q, valid_q;
   logic [NUM_BOOTHS-1:0] ack_q, elig;
   logic [PTR_W-1:0]      ptr_q, idx, win;
   logic [CNT_W-1:0]      c1_q, c2_q, nulo_q;
   logic [1:0]            sel_q, code;
   logic                  start_e, finish_e, gnt;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
   assign start_e  = bus.start & ~start_q;
   assign finish_e = bus.finish & ~finish_q;
   assign code     = 2'(bus.vote >> {win, 1'b0});
   // a booth acked this cycle is masked so it cannot win twice in a row
   always_comb begin
      elig = bus.req & ~ack_q;
      gnt  = 1'b0;
      win  = ptr_q;
      idx  = ptr_q;
      // scan downward so the eligible booth nearest the pointer is written last
      for (int k = NUM_BOOTHS - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(ptr_q) + k) % NUM_BOOTHS);
         if (elig[idx]) begin
            gnt = 1'b1;
            win = idx;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q  <= IDLE;
         start_q  <= 1'b0;
         finish_q <= 1'b0;
         ack_q    <= '0;
         ptr_q    <= '0;
         c1_q     <= '0;
         c2_q     <= '0;
         nulo_q   <= '0;
         sel_q    <= 2'd0;
         valid_q  <= 1'b0;
      end else begin
         start_q  <= bus.start;
         finish_q <= bus.finish;
         ack_q    <= '0;
         case (phase_q)
            IDLE: if (start_e) begin
               phase_q <= OPEN;
               c1_q    <= '0;
               c2_q    <= '0;
               nulo_q  <= '0;
            end
            OPEN: if (finish_e) begin
               phase_q <= CLOSED;
               sel_q   <= 2'd0;
               valid_q <= 1'b1;
            end else if (gnt) begin
               ack_q <= NUM_BOOTHS'(1) << win;
               ptr_q <= (int'(win) == NUM_BOOTHS - 1) ? '0 : win + 1'b1;
               if (code == 2'd0) c1_q <= sat_inc(c1_q);
               else if (code == 2'd1) c2_q <= sat_inc(c2_q);
               else nulo_q <= sat_inc(nulo_q);
            end
            CLOSED: if (start_e) begin
               phase_q <= OPEN;
               c1_q    <= '0;
               c2_q    <= '0;
               nulo_q  <= '0;
               sel_q   <= 2'd0;
               valid_q <= 1'b0;
            end else if (finish_e) begin
               sel_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            end
            default: phase_q <= IDLE;
         endcase
      end
   end
   assign bus.ack          = ack_q;
   assign bus.phase        = phase_q;
   assign bus.count_c1     = c1_q;
   assign bus.count_c2     = c2_q;
   assign bus.count_nulo   = nulo_q;
   assign bus.result_sel   = sel_q;
   assign bus.result_valid = valid_q;
   assign bus.result_value = (phase_q != CLOSED) ? '0 : (sel_q == 2'd0) ? c1_q : (sel_q == 2'd1) ? c2_q : nulo_q;
endmodule

// File: tb/tb_vote_tally_arbiter.sv
// tb_vote_tally_arbiter: scoreboard bench for vote_tally_arbiter against an election-rules model
module tb_vote_tally_arbiter;
   localparam int NB   = 2;
   localparam int W    = 8;
   localparam int MAXC = (1 << W) - 1;
   typedef struct {
      int ack;
      int phase;
      int c1;
      int c2;
      int cn;
      int sel;
      int val;
      int valid;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   vote_tally_arbiter_if #(.NUM_BOOTHS(NB), .CNT_W(W)) bus ();
   vote_tally_arbiter #(.NUM_BOOTHS(NB), .CNT_W(W)) dut (.clock(clk), .reset(rst), .bus(bus.slave));
   int   checks, failures;
   exp_t exp_q[$];
   exp_t me;
   int   m_phase, m_ptr, m_sel;
   int   m_cnt[3];
   bit   m_st_q, m_fi_q;
   bit   m_ack[NB];
   bit   r, st, fi;
   bit   req_b[NB];
   int   vote_b[NB];
   int   bst[NB];
   int   mode, pct;
   task automatic chk(input string n, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp_v, $time);
      end
   endtask
   // election rules applied at one clock edge, expected outputs queued for the monitor
   task automatic model_edge();
      bit   se, fe;
      bit   prev[NB];
      int   win, t;
      exp_t e;
      se = st && !m_st_q;
      fe = fi && !m_fi_q;
      prev = m_ack;
      foreach (m_ack[i]) m_ack[i] = 0;
      m_st_q = st;
      m_fi_q = fi;
      if (r) begin
         m_phase = 0; m_ptr = 0; m_sel = 0; m_cnt = '{0, 0, 0}; m_st_q = 0; m_fi_q = 0;
      end else if (m_phase == 0) begin
         if (se) begin m_phase = 1; m_cnt = '{0, 0, 0}; end
      end else if (m_phase == 1) begin
         if (fe) begin
            m_phase = 2; m_sel = 0;
         end else begin
            win = -1;
            for (int k = 0; k < NB; k++)
               if (win < 0 && req_b[(m_ptr + k) % NB] && !prev[(m_ptr + k) % NB]) win = (m_ptr + k) % NB;
            if (win >= 0) begin
               t = (vote_b[win] >= 2) ? 2 : vote_b[win];
               m_cnt[t] = (m_cnt[t] < MAXC) ? m_cnt[t] + 1 : MAXC;
               m_ack[win] = 1;
               m_ptr = (win + 1) % NB;
            end
         end
      end else begin
         if (se) begin m_phase = 1; m_sel = 0; m_cnt = '{0, 0, 0}; end
         else if (fe) m_sel = (m_sel + 1) % 3;
      end
      e.ack = 0;
      foreach (m_ack[i]) if (m_ack[i]) e.ack |= (1 << i);
      e.phase = m_phase;
      e.c1    = m_cnt[0];
      e.c2    = m_cnt[1];
      e.cn    = m_cnt[2];
      e.sel   = m_sel;
      e.valid = (m_phase == 2) ? 1 : 0;
      e.val   = (m_phase == 2) ? m_cnt[m_sel] : 0;
      exp_q.push_back(e);
   endtask
   // booth behaviour: mode 1 = request, hold until acked plus one cycle, then drop; mode 2 = hold always
   task automatic update_booths();
      for (int i = 0; i < NB; i++) begin
         if (mode == 2) req_b[i] = 1;
         else if (m_ack[i]) bst[i] = 2;
         else if (bst[i] == 2) begin bst[i] = 0; req_b[i] = 0; end
         else if (bst[i] == 0 && $urandom_range(0, 99) < pct) begin
            bst[i] = 1; req_b[i] = 1; vote_b[i] = $urandom_range(0, 3);
         end
      end
   endtask
   task automatic tick();
      @(negedge clk);
      update_booths();
      rst = r;
      bus.start = st;
      bus.finish = fi;
      for (int i = 0; i < NB; i++) begin
         bus.req[i] = req_b[i];
         bus.vote[2*i +: 2] = 2'(vote_b[i]);
      end
      model_edge();
   endtask
   task automatic ticks(input int n);
      repeat (n) tick();
   endtask
   task automatic pulse_start();
      st = 1; tick(); st = 0; tick();
   endtask
   task automatic pulse_finish();
      fi = 1; tick(); fi = 0; tick();
   endtask
   task automatic vote1(input int b, input int code);
      req_b[b] = 1; vote_b[b] = code; bst[b] = 1; ticks(3);
   endtask
   task automatic idle_booths();
      mode = 1; pct = 0;
      for (int i = 0; i < NB; i++) begin req_b[i] = 0; bst[i] = 0; end
   endtask
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         chk("ack", int'(bus.ack), me.ack);
         chk("phase", int'(bus.phase), me.phase);
         chk("count_c1", int'(bus.count_c1), me.c1);
         chk("count_c2", int'(bus.count_c2), me.c2);
         chk("count_nulo", int'(bus.count_nulo), me.cn);
         chk("result_sel", int'(bus.result_sel), me.sel);
         chk("result_value", int'(bus.result_value), me.val);
         chk("result_valid", int'(bus.result_valid), me.valid);
      end
   end
   initial begin
      checks = 0; failures = 0;
      r = 1; st = 0; fi = 0;
      bus.start = 0; bus.finish = 0; bus.req = '0; bus.vote = '0;
      idle_booths();
      for (int i = 0; i < NB; i++) vote_b[i] = 0;
      ticks(2);
      r = 0;
      fi = 1; ticks(2); fi = 0;
      req_b[0] = 1; ticks(3); req_b[0] = 0;
      st = 1; ticks(3); st = 0; tick();
      req_b = '{1, 1}; vote_b = '{0, 1}; bst = '{1, 1};
      ticks(4);
      mode = 2; vote_b = '{2, 3};
      ticks(6);
      idle_booths(); tick();
      mode = 2; vote_b = '{0, 0};
      ticks(256);
      idle_booths(); ticks(2);
      chk("c1_saturated", int'(bus.count_c1), MAXC);
      req_b = '{1, 1}; bst = '{1, 1}; vote_b = '{0, 2};
      fi = 1; tick(); fi = 0; tick();
      repeat (3) pulse_finish();
      chk("closed_phase", int'(bus.phase), 2);
      chk("closed_no_ack", int'(bus.ack), 0);
      idle_booths(); tick();
      pulse_start();
      vote1(0, 0); vote1(1, 0); vote1(0, 1); vote1(1, 2); vote1(0, 3); vote1(1, 2);
      pulse_finish();
      repeat (3) pulse_finish();
      pulse_start();
      vote1(1, 1);
      chk("reopen_phase", int'(bus.phase), 1);
      chk("reopen_c1", int'(bus.count_c1), 0);
      chk("reopen_c2", int'(bus.count_c2), 1);
      chk("reopen_nulo", int'(bus.count_nulo), 0);
      chk("reopen_valid", int'(bus.result_valid), 0);
      mode = 1; pct = 35;
      for (int n = 0; n < 1500; n++) begin
         st = ($urandom_range(0, 24) == 0);
         fi = ($urandom_range(0, 19) == 0);
         r  = ($urandom_range(0, 299) == 0);
         tick();
      end
      st = 0; fi = 0; r = 0;
      idle_booths();
      r = 1; tick(); r = 0; tick();
      pulse_start();
      mode = 2; vote_b = '{1, 1};
      ticks(3);
      r = 1; tick(); r = 0;
      ticks(3);
      chk("rst_phase", int'(bus.phase), 0);
      chk("rst_ack", int'(bus.ack), 0);
      chk("rst_c2", int'(bus.count_c2), 0);
      idle_booths(); ticks(2);
      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
